// File: rtl/regfile_sb.sv
// Register file with per-entry byte-enable writes, optional write-to-read
// forwarding and a pending-producer scoreboard (one busy bit per entry).
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   ra1/ra2 -> rd1/rd2: two independent combinational read ports
//   busy1/busy2       : registered busy bits of entries ra1/ra2
//   we/wa/wd/wbe      : byte-masked write; a write also clears busy[wa]
//   alloc/aa          : marks entry aa busy (producer issued)
//   pend_cnt          : number of busy entries
//   full_busy         : every allocatable entry is busy
module regfile_sb #(
    parameter int DW      = 32,
    parameter int AW      = 3,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   ra1,
    input  logic [AW-1:0]   ra2,
    output logic [DW-1:0]   rd1,
    output logic [DW-1:0]   rd2,
    output logic            busy1,
    output logic            busy2,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [DW-1:0]   wd,
    input  logic [DW/8-1:0] wbe,
    input  logic            alloc,
    input  logic [AW-1:0]   aa,
    output logic [AW:0]     pend_cnt,
    output logic            full_busy
);

    localparam int DEPTH = 1 << AW;
    localparam int NB    = DW / 8;
    // Entry 0 is never allocatable when it is hard-wired to zero.
    localparam int CAP   = DEPTH - ((ZERO_R0 != 0) ? 1 : 0);

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;
    logic             wr_ok;
    logic             alloc_ok;

    // Enabled bytes come from the write data, the rest from the old word.
    function automatic logic [DW-1:0] merge(input logic [DW-1:0]   old,
                                            input logic [DW-1:0]   d,
                                            input logic [DW/8-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    // Forwarding is suppressed during reset: the write will not land.
    function automatic logic [DW-1:0] read_port(input logic [AW-1:0] ra,
                                                input logic [DW-1:0] stored);
        logic [DW-1:0] r;
        if ((ZERO_R0 != 0) && (ra == '0)) begin
            r = '0;
        end else if ((BYPASS != 0) && we && !rst && (wa == ra)) begin
            r = merge(stored, wd, wbe);
        end else begin
            r = stored;
        end
        return r;
    endfunction

    assign wr_ok    = we && !((ZERO_R0 != 0) && (wa == '0));
    // An alloc arriving while everything is busy is dropped entirely.
    assign alloc_ok = alloc && !full_busy && !((ZERO_R0 != 0) && (aa == '0));

    // Clear first, then set: a same-cycle alloc to the written entry
    // represents a newer producer and must leave the entry busy.
    always_comb begin
        busy_nxt = busy;
        if (we)       busy_nxt[wa] = 1'b0;
        if (alloc_ok) busy_nxt[aa] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) mem[wa] <= merge(mem[wa], wd, wbe);
            busy <= busy_nxt;
        end
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < DEPTH; i++) pend_cnt = pend_cnt + (AW+1)'(busy[i]);
    end

    assign full_busy = (pend_cnt == (AW+1)'(CAP));

    assign rd1   = read_port(ra1, mem[ra1]);
    assign rd2   = read_port(ra2, mem[ra2]);
    assign busy1 = busy[ra1];
    assign busy2 = busy[ra2];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances share stimulus, one with default
// parameters (forwarding on, entry 0 writable) and one with ZERO_R0=1 and
// BYPASS=0, each tracked by its own array-based reference model.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [2:0]  ra1, ra2, wa, aa;
    logic        we, alloc;
    logic [31:0] wd;
    logic [3:0]  wbe;

    logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_busy1, a_busy2, b_busy1, b_busy2;
    logic [3:0]  a_cnt, b_cnt;
    logic        a_full, b_full;

    int passed = 0;
    int total  = 0;

    // reference state: a = default instance, b = zero-r0 / no-forward
    logic [31:0] ma [8];
    logic [31:0] mb [8];
    logic [7:0]  ba, bb;

    regfile_sb #(.DW(32), .AW(3), .ZERO_R0(0), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(a_rd1), .rd2(a_rd2),
        .busy1(a_busy1), .busy2(a_busy2), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
        .alloc(alloc), .aa(aa), .pend_cnt(a_cnt), .full_busy(a_full));

    regfile_sb #(.DW(32), .AW(3), .ZERO_R0(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2),
        .busy1(b_busy1), .busy2(b_busy2), .we(we), .wa(wa), .wd(wd), .wbe(wbe),
        .alloc(alloc), .aa(aa), .pend_cnt(b_cnt), .full_busy(b_full));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mrg(input logic [31:0] old);
        logic [31:0] mask;
        mask = 32'h0;
        for (int k = 0; k < 4; k++) if (wbe[k]) mask = mask | (32'hFF << (8 * k));
        return (old & ~mask) | (wd & mask);
    endfunction

    function automatic int popc(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic logic [31:0] exp_a(input logic [2:0] ra);
        if (we && !rst && wa == ra) return mrg(ma[ra]);
        return ma[ra];
    endfunction

    function automatic logic [31:0] exp_b(input logic [2:0] ra);
        if (ra == 3'd0) return 32'h0;
        return mb[ra];
    endfunction

    // advance the reference across one rising edge using the held inputs
    task automatic mdl_edge();
        int ca, cb;
        ca = popc(ba);
        cb = popc(bb);
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                ma[i] = 32'h0;
                mb[i] = 32'h0;
            end
            ba = 8'h0;
            bb = 8'h0;
        end else begin
            if (we) begin
                ma[wa] = mrg(ma[wa]);
                ba[wa] = 1'b0;
                if (wa != 3'd0) mb[wa] = mrg(mb[wa]);
                bb[wa] = 1'b0;
            end
            if (alloc) begin
                if (ca < 8) ba[aa] = 1'b1;
                if (cb < 7 && aa != 3'd0) bb[aa] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_edge();
        #1;
    endtask

    task automatic idle();
        we = 1'b0; alloc = 1'b0; rst = 1'b0;
        wa = 3'd0; aa = 3'd0; wd = 32'h0; wbe = 4'h0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; we = 1'b1; alloc = 1'b1; wd = 32'hDEADBEEF; wbe = 4'hF;
        tick();
        idle();
        for (int i = 0; i < 8; i++) begin
            ra1 = 3'(i); ra2 = 3'(7 - i);
            #1;
            total++;
            if (a_rd1 !== 32'h0 || a_rd2 !== 32'h0 || b_rd1 !== 32'h0 || b_rd2 !== 32'h0) begin
                $display("FAIL reset_rd entry %0d: got a=%h/%h b=%h/%h want 0", i, a_rd1, a_rd2, b_rd1, b_rd2);
            end else passed++;
            total++;
            if ({a_busy1, a_busy2, b_busy1, b_busy2} !== 4'b0) begin
                $display("FAIL reset_busy entry %0d: got %b want 0000", i, {a_busy1, a_busy2, b_busy1, b_busy2});
            end else passed++;
        end
        total++;
        if (a_cnt !== 4'd0 || b_cnt !== 4'd0 || a_full !== 1'b0 || b_full !== 1'b0) begin
            $display("FAIL reset_cnt: got cnt %0d/%0d full %b/%b want 0", a_cnt, b_cnt, a_full, b_full);
        end else passed++;
    endtask

    task automatic test_byte_enable();
        idle();
        we = 1'b1; wa = 3'd3; wd = 32'hAABBCCDD; wbe = 4'hF;
        tick();
        wd = 32'h11223344; wbe = 4'b0101;
        tick();
        idle();
        ra1 = 3'd3; ra2 = 3'd3;
        #1;
        total++;
        if (a_rd1 !== 32'hAA22CC44 || b_rd2 !== 32'hAA22CC44) begin
            $display("FAIL byte_enable: got a=%h b=%h want aa22cc44", a_rd1, b_rd2);
        end else passed++;
        // zero byte enables: data unchanged, busy still cleared
        alloc = 1'b1; aa = 3'd3;
        tick();
        idle();
        we = 1'b1; wa = 3'd3; wd = 32'hFFFFFFFF; wbe = 4'h0;
        tick();
        idle();
        #1;
        total++;
        if (a_rd1 !== 32'hAA22CC44 || a_busy1 !== 1'b0 || b_busy1 !== 1'b0) begin
            $display("FAIL wbe_zero: got rd=%h busy=%b/%b want aa22cc44 0/0", a_rd1, a_busy1, b_busy1);
        end else passed++;
    endtask

    task automatic test_bypass();
        idle();
        ra1 = 3'd5; ra2 = 3'd4;
        we = 1'b1; wa = 3'd5; wd = 32'h12345678; wbe = 4'hF;
        #1;
        total++;
        if (a_rd1 !== 32'h12345678) begin
            $display("FAIL bypass_same_cycle: got %h want 12345678", a_rd1);
        end else passed++;
        total++;
        if (b_rd1 !== 32'h0) begin
            $display("FAIL no_bypass_old: got %h want 00000000", b_rd1);
        end else passed++;
        tick();
        idle();
        #1;
        total++;
        if (b_rd1 !== 32'h12345678 || a_rd1 !== 32'h12345678) begin
            $display("FAIL bypass_next_cycle: got a=%h b=%h want 12345678", a_rd1, b_rd1);
        end else passed++;
    endtask

    task automatic test_scoreboard();
        idle();
        ra1 = 3'd2; ra2 = 3'd2;
        alloc = 1'b1; aa = 3'd2;
        #1;
        total++;
        if (a_busy1 !== 1'b0) begin
            $display("FAIL busy_not_forwarded: got %b want 0", a_busy1);
        end else passed++;
        tick();
        idle();
        #1;
        total++;
        if (a_busy1 !== 1'b1 || b_busy2 !== 1'b1 || a_cnt !== 4'd1 || b_cnt !== 4'd1) begin
            $display("FAIL alloc_set: got busy %b/%b cnt %0d/%0d want 1/1 1/1", a_busy1, b_busy2, a_cnt, b_cnt);
        end else passed++;
        alloc = 1'b1; aa = 3'd2; we = 1'b1; wa = 3'd2; wd = 32'hCAFEF00D; wbe = 4'hF;
        tick();
        idle();
        #1;
        total++;
        if (a_busy1 !== 1'b1 || b_busy1 !== 1'b1 || a_cnt !== 4'd1 || a_rd1 !== 32'hCAFEF00D || b_rd1 !== 32'hCAFEF00D) begin
            $display("FAIL alloc_and_write: got busy %b/%b cnt %0d rd %h/%h want 1/1 1 cafef00d", a_busy1, b_busy1, a_cnt, a_rd1, b_rd1);
        end else passed++;
        we = 1'b1; wa = 3'd2; wd = 32'h0; wbe = 4'h0;
        tick();
        idle();
        #1;
        total++;
        if (a_busy1 !== 1'b0 || b_busy1 !== 1'b0 || a_cnt !== 4'd0 || b_cnt !== 4'd0) begin
            $display("FAIL write_clears: got busy %b/%b cnt %0d/%0d want 0", a_busy1, b_busy1, a_cnt, b_cnt);
        end else passed++;
        // alloc and write to different entries in the same edge
        alloc = 1'b1; aa = 3'd6; we = 1'b1; wa = 3'd1; wd = 32'h5A5A5A5A; wbe = 4'hF;
        tick();
        idle();
        ra1 = 3'd6; ra2 = 3'd1;
        #1;
        total++;
        if (a_busy1 !== 1'b1 || a_rd2 !== 32'h5A5A5A5A || b_busy1 !== 1'b1 || b_rd2 !== 32'h5A5A5A5A) begin
            $display("FAIL alloc_write_split: got busy %b/%b rd %h/%h", a_busy1, b_busy1, a_rd2, b_rd2);
        end else passed++;
        we = 1'b1; wa = 3'd6; wbe = 4'h0;
        tick();
        idle();
    endtask

    task automatic test_zero_r0();
        idle();
        alloc = 1'b1; aa = 3'd0; we = 1'b1; wa = 3'd0; wd = 32'hFFFFFFFF; wbe = 4'hF;
        tick();
        idle();
        ra1 = 3'd0; ra2 = 3'd0;
        we = 1'b1; wa = 3'd0; wd = 32'h87654321; wbe = 4'hF;
        #1;
        total++;
        if (b_rd1 !== 32'h0 || b_busy1 !== 1'b0 || b_cnt !== 4'd0) begin
            $display("FAIL zero_r0: got rd %h busy %b cnt %0d want 0", b_rd1, b_busy1, b_cnt);
        end else passed++;
        total++;
        if (a_rd1 !== 32'h87654321 || a_busy1 !== 1'b1) begin
            $display("FAIL r0_normal: got rd %h busy %b want 87654321 1", a_rd1, a_busy1);
        end else passed++;
        idle();
        for (int i = 1; i < 8; i++) begin
            alloc = 1'b1; aa = 3'(i);
            tick();
        end
        idle();
        #1;
        total++;
        if (b_full !== 1'b1 || b_cnt !== 4'd7 || a_full !== 1'b1 || a_cnt !== 4'd8) begin
            $display("FAIL full_busy: got full %b/%b cnt %0d/%0d want 1/1 8/7", a_full, b_full, a_cnt, b_cnt);
        end else passed++;
        // alloc while full is dropped even when it coincides with a write
        alloc = 1'b1; aa = 3'd4; we = 1'b1; wa = 3'd4; wd = 32'h0; wbe = 4'h0;
        tick();
        idle();
        ra1 = 3'd4;
        #1;
        total++;
        if (b_cnt !== 4'd6 || a_cnt !== 4'd7 || b_busy1 !== 1'b0 || b_full !== 1'b0) begin
            $display("FAIL alloc_when_full: got cnt %0d/%0d busy %b full %b want 7/6 0 0", a_cnt, b_cnt, b_busy1, b_full);
        end else passed++;
    endtask

    task automatic test_reset_midstream();
        idle();
        rst = 1'b1; we = 1'b1; wa = 3'd3; wd = 32'h01020304; wbe = 4'hF;
        alloc = 1'b1; aa = 3'd4; ra1 = 3'd3; ra2 = 3'd1;
        #1;
        total++;
        if (a_rd1 !== ma[3] || a_rd2 !== ma[1]) begin
            $display("FAIL rst_no_bypass: got %h/%h want %h/%h", a_rd1, a_rd2, ma[3], ma[1]);
        end else passed++;
        tick();
        idle();
        for (int i = 0; i < 8; i++) begin
            ra1 = 3'(i); ra2 = 3'(i);
            #1;
            total++;
            if (a_rd1 !== 32'h0 || b_rd2 !== 32'h0 || a_busy1 !== 1'b0 || b_busy2 !== 1'b0) begin
                $display("FAIL rst_midstream entry %0d: got rd %h/%h busy %b/%b want 0", i, a_rd1, b_rd2, a_busy1, b_busy2);
            end else passed++;
        end
        total++;
        if (a_cnt !== 4'd0 || b_cnt !== 4'd0) begin
            $display("FAIL rst_midstream_cnt: got %0d/%0d want 0", a_cnt, b_cnt);
        end else passed++;
    endtask

    task automatic test_random(input int n);
        for (int c = 0; c < n; c++) begin
            rst   = ($urandom_range(0, 63) == 0);
            we    = ($urandom_range(0, 9) < 4);
            alloc = ($urandom_range(0, 9) < 6);
            wa    = 3'($urandom_range(0, 7));
            aa    = 3'($urandom_range(0, 7));
            ra1   = ($urandom_range(0, 3) == 0) ? wa : 3'($urandom_range(0, 7));
            ra2   = 3'($urandom_range(0, 7));
            wd    = $urandom;
            wbe   = 4'($urandom_range(0, 15));
            #1;
            total++;
            if (a_rd1 !== exp_a(ra1) || a_rd2 !== exp_a(ra2)) begin
                $display("FAIL rand_a_rd cyc %0d: got %h/%h want %h/%h", c, a_rd1, a_rd2, exp_a(ra1), exp_a(ra2));
            end else passed++;
            total++;
            if (b_rd1 !== exp_b(ra1) || b_rd2 !== exp_b(ra2)) begin
                $display("FAIL rand_b_rd cyc %0d: got %h/%h want %h/%h", c, b_rd1, b_rd2, exp_b(ra1), exp_b(ra2));
            end else passed++;
            total++;
            if (a_busy1 !== ba[ra1] || a_busy2 !== ba[ra2] || b_busy1 !== bb[ra1] || b_busy2 !== bb[ra2]) begin
                $display("FAIL rand_busy cyc %0d: got %b want %b", c, {a_busy1, a_busy2, b_busy1, b_busy2}, {ba[ra1], ba[ra2], bb[ra1], bb[ra2]});
            end else passed++;
            total++;
            if (int'(a_cnt) != popc(ba) || int'(b_cnt) != popc(bb)
                || a_full !== (popc(ba) == 8) || b_full !== (popc(bb) == 7)) begin
                $display("FAIL rand_cnt cyc %0d: got cnt %0d/%0d full %b/%b want %0d/%0d", c, a_cnt, b_cnt, a_full, b_full, popc(ba), popc(bb));
            end else passed++;
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1; ra1 = 3'd0; ra2 = 3'd0;
        for (int i = 0; i < 8; i++) begin
            ma[i] = 32'h0;
            mb[i] = 32'h0;
        end
        ba = 8'h0;
        bb = 8'h0;
        #1;
        test_reset();
        test_byte_enable();
        test_bypass();
        test_scoreboard();
        test_zero_r0();
        test_reset_midstream();
        test_random(600);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
